sysid_checker: RTL and testbench

SYSID_CHECKER -- requirements
Module: sysid_checker

---
 rtl/sysid_checker_pkg.sv | 23 ++
 rtl/sysid_wait_timer.sv | 35 +++
 rtl/sysid_checker.sv | 164 ++++++++++++++++
 tb/tb_sysid_checker.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/sysid_checker_pkg.sv
// Shared types and constants for the sysid checker: FSM state encoding,
// slave word addresses and the default expected system-ID contents.
package sysid_checker_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RD_ID = 2'd1,
    RD_TS = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam logic ADDR_ID = 1'b0;
  localparam logic ADDR_TS = 1'b1;

  localparam logic [31:0] DEF_EXPECTED_ID = 32'd58678540;
  localparam logic [31:0] DEF_EXPECTED_TS = 32'd1283946474;
  localparam int unsigned DEF_TIMEOUT     = 255;

  function automatic logic word_match(input logic [31:0] got, input logic [31:0] want);
    return got == want;
  endfunction

endpackage

// File: rtl/sysid_wait_timer.sv
// Stall counter for one Avalon read: counts waitrequest cycles and flags
// expiry once LIMIT stalls have already been absorbed and the slave still stalls.
module sysid_wait_timer #(
  parameter logic [7:0] LIMIT = 8'd255
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clear,
  input  logic stall,
  output logic expired
);

  logic [7:0] count_q;
  logic [7:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = 8'd0;
    end else if (stall && (count_q != 8'hFF)) begin
      count_d = count_q + 8'd1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= 8'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = stall && (count_q == LIMIT);

endmodule

// File: rtl/sysid_checker.sv
// Reads the system-ID and build-timestamp words from an Avalon-MM sysid slave
// and compares them against expected values, aborting on an excessive stall.
module sysid_checker
  import sysid_checker_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID = DEF_EXPECTED_ID,
  parameter logic [31:0] EXPECTED_TS = DEF_EXPECTED_TS,
  parameter int unsigned TIMEOUT     = DEF_TIMEOUT
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic [31:0] avm_readdata,
  input  logic        avm_waitrequest,
  output logic        busy,
  output logic        done,
  output logic        id_ok,
  output logic        ts_ok,
  output logic        timeout_err,
  output logic [31:0] id_value,
  output logic [31:0] ts_value
);

  state_e      state_q, state_d;
  logic        read_q, read_d;
  logic        addr_q, addr_d;
  logic        done_q, done_d;
  logic        id_ok_q, id_ok_d;
  logic        ts_ok_q, ts_ok_d;
  logic        terr_q, terr_d;
  logic [31:0] id_value_q, id_value_d;
  logic [31:0] ts_value_q, ts_value_d;

  logic timer_clear;
  logic timer_stall;
  logic timer_expired;

  sysid_wait_timer #(
    .LIMIT(8'(TIMEOUT))
  ) u_wait_timer (
    .clock  (clock),
    .reset_n(reset_n),
    .clear  (timer_clear),
    .stall  (timer_stall),
    .expired(timer_expired)
  );

  // Strobe and address are computed for the next state so they leave the
  // flops aligned with it and stay put while the slave stalls.
  always_comb begin
    state_d     = state_q;
    read_d      = 1'b0;
    addr_d      = ADDR_ID;
    done_d      = 1'b0;
    id_ok_d     = id_ok_q;
    ts_ok_d     = ts_ok_q;
    terr_d      = terr_q;
    id_value_d  = id_value_q;
    ts_value_d  = ts_value_q;
    timer_clear = 1'b1;
    timer_stall = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = RD_ID;
          read_d     = 1'b1;
          addr_d     = ADDR_ID;
          id_ok_d    = 1'b0;
          ts_ok_d    = 1'b0;
          terr_d     = 1'b0;
          id_value_d = 32'd0;
          ts_value_d = 32'd0;
        end
      end

      RD_ID: begin
        timer_clear = 1'b0;
        timer_stall = avm_waitrequest;
        read_d      = 1'b1;
        addr_d      = ADDR_ID;
        if (!avm_waitrequest) begin
          id_value_d  = avm_readdata;
          id_ok_d     = word_match(avm_readdata, EXPECTED_ID);
          state_d     = RD_TS;
          addr_d      = ADDR_TS;
          timer_clear = 1'b1;
        end else if (timer_expired) begin
          terr_d  = 1'b1;
          state_d = DONE;
          read_d  = 1'b0;
          done_d  = 1'b1;
        end
      end

      RD_TS: begin
        timer_clear = 1'b0;
        timer_stall = avm_waitrequest;
        read_d      = 1'b1;
        addr_d      = ADDR_TS;
        if (!avm_waitrequest) begin
          ts_value_d  = avm_readdata;
          ts_ok_d     = word_match(avm_readdata, EXPECTED_TS);
          state_d     = DONE;
          read_d      = 1'b0;
          addr_d      = ADDR_ID;
          done_d      = 1'b1;
          timer_clear = 1'b1;
        end else if (timer_expired) begin
          terr_d  = 1'b1;
          state_d = DONE;
          read_d  = 1'b0;
          addr_d  = ADDR_ID;
          done_d  = 1'b1;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      read_q     <= 1'b0;
      addr_q     <= ADDR_ID;
      done_q     <= 1'b0;
      id_ok_q    <= 1'b0;
      ts_ok_q    <= 1'b0;
      terr_q     <= 1'b0;
      id_value_q <= 32'd0;
      ts_value_q <= 32'd0;
    end else begin
      state_q    <= state_d;
      read_q     <= read_d;
      addr_q     <= addr_d;
      done_q     <= done_d;
      id_ok_q    <= id_ok_d;
      ts_ok_q    <= ts_ok_d;
      terr_q     <= terr_d;
      id_value_q <= id_value_d;
      ts_value_q <= ts_value_d;
    end
  end

  assign avm_read    = read_q;
  assign avm_address = addr_q;
  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign id_ok       = id_ok_q;
  assign ts_ok       = ts_ok_q;
  assign timeout_err = terr_q;
  assign id_value    = id_value_q;
  assign ts_value    = ts_value_q;

endmodule

// File: tb/tb_sysid_checker.sv
// Randomized bench for sysid_checker: a programmable stalling slave plus a
// transaction-level model predicting the per-cycle trace and final status.
module tb_sysid_checker;

  localparam logic [31:0] EXP_ID = 32'd58678540;
  localparam logic [31:0] EXP_TS = 32'd1283946474;
  localparam int          T      = 4;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        start;
  logic        avm_address;
  logic        avm_read;
  logic [31:0] avm_readdata;
  logic        avm_waitrequest;
  logic        busy;
  logic        done;
  logic        id_ok;
  logic        ts_ok;
  logic        timeout_err;
  logic [31:0] id_value;
  logic [31:0] ts_value;

  int n_checks = 0;
  int n_errors = 0;

  // slave programming and state
  int          w_stall [2];
  logic [31:0] rd_word [2];
  logic        prev_read;
  logic        prev_addr;
  int          scnt;

  // last predicted status, for hold checks
  logic [2:0]  last_flags;
  logic [63:0] last_vals;

  sysid_checker #(
    .EXPECTED_ID(EXP_ID),
    .EXPECTED_TS(EXP_TS),
    .TIMEOUT    (T)
  ) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .start          (start),
    .avm_address    (avm_address),
    .avm_read       (avm_read),
    .avm_readdata   (avm_readdata),
    .avm_waitrequest(avm_waitrequest),
    .busy           (busy),
    .done           (done),
    .id_ok          (id_ok),
    .ts_ok          (ts_ok),
    .timeout_err    (timeout_err),
    .id_value       (id_value),
    .ts_value       (ts_value)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Slave answers each read after w_stall[addr] stalled cycles; garbage data while stalled.
  task automatic slave_drive();
    if (avm_read) begin
      if (!prev_read || (avm_address != prev_addr)) scnt = 0;
      else scnt++;
      avm_waitrequest = (scnt < w_stall[avm_address]);
      avm_readdata    = avm_waitrequest ? $urandom : rd_word[avm_address];
    end else begin
      avm_waitrequest = 1'($urandom_range(0, 1));
      avm_readdata    = $urandom;
    end
    prev_read = avm_read;
    prev_addr = avm_address;
  endtask

  // One accepted start with the given stall counts and slave data.
  task automatic run_seq(input int wi, input int wt, input logic [31:0] di,
                         input logic [31:0] dt, input bit repulse);
    bit to_id, to_ts;
    int id_len, ts_len, d_cyc;
    logic [3:0] exp_vec;
    to_id  = (wi > T);
    to_ts  = !to_id && (wt > T);
    id_len = to_id ? T + 1 : wi + 1;
    ts_len = to_id ? 0 : (to_ts ? T + 1 : wt + 1);
    d_cyc  = 1 + id_len + ts_len;
    w_stall[0] = wi;
    w_stall[1] = wt;
    rd_word[0] = di;
    rd_word[1] = dt;
    prev_read  = 1'b0;
    start      = 1'b1;
    slave_drive();
    for (int k = 1; k <= d_cyc + 1; k++) begin
      @(posedge clock);
      #1;
      if (k <= id_len)               exp_vec = 4'b1010;
      else if (k <= id_len + ts_len) exp_vec = 4'b1011;
      else if (k == d_cyc)           exp_vec = 4'b1100;
      else                           exp_vec = 4'b0000;
      check_eq($sformatf("trace{busy,done,read,addr} k=%0d wi=%0d wt=%0d", k, wi, wt),
               {60'd0, busy, done, avm_read, avm_address}, {60'd0, exp_vec});
      if (k == 1) begin
        check_eq("cleared_flags", {61'd0, timeout_err, id_ok, ts_ok}, 64'd0);
        check_eq("cleared_vals", {id_value, ts_value}, 64'd0);
      end
      if (k == d_cyc + 1) begin
        last_flags = {to_id || to_ts, !to_id && (di == EXP_ID),
                      !to_id && !to_ts && (dt == EXP_TS)};
        last_vals  = {to_id ? 32'd0 : di, (to_id || to_ts) ? 32'd0 : dt};
        check_eq("status_flags{terr,id_ok,ts_ok}", {61'd0, timeout_err, id_ok, ts_ok},
                 {61'd0, last_flags});
        check_eq("status_vals{id,ts}", {id_value, ts_value}, last_vals);
      end
      if (repulse && k < d_cyc)   start = 1'($urandom_range(0, 1));
      else if (repulse && k == d_cyc) start = 1'b1;
      else                        start = 1'b0;
      slave_drive();
    end
    start = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      start = 1'b0;
      slave_drive();
      @(posedge clock);
      #1;
    end
    if (n > 0) begin
      check_eq("hold_flags", {61'd0, timeout_err, id_ok, ts_ok}, {61'd0, last_flags});
      check_eq("hold_vals", {id_value, ts_value}, last_vals);
      check_eq("hold_idle{busy,done,read}", {61'd0, busy, done, avm_read}, 64'd0);
    end
  endtask

  initial begin
    reset_n         = 1'b0;
    start           = 1'b0;
    avm_waitrequest = 1'b0;
    avm_readdata    = 32'd0;
    prev_read       = 1'b0;
    prev_addr       = 1'b0;
    scnt            = 0;
    w_stall[0]      = 0;
    w_stall[1]      = 0;
    rd_word[0]      = 32'd0;
    rd_word[1]      = 32'd0;
    repeat (3) @(posedge clock);
    #1;
    check_eq("reset_ctrl", {57'd0, busy, done, avm_read, avm_address, id_ok, ts_ok, timeout_err},
             64'd0);
    check_eq("reset_vals", {id_value, ts_value}, 64'd0);
    reset_n = 1'b1;
    @(posedge clock);
    #1;

    run_seq(0, 0, EXP_ID, EXP_TS, 0);
    idle_cycles(2);
    run_seq(0, 0, 32'd0, EXP_TS, 0);
    idle_cycles(1);
    run_seq(3, 3, EXP_ID, EXP_TS, 0);
    run_seq(0, 255, EXP_ID, EXP_TS, 0);
    idle_cycles(2);
    run_seq(255, 0, EXP_ID, EXP_TS, 0);
    run_seq(T, T, EXP_ID, 32'hDEADBEEF, 0);
    run_seq(T + 1, 0, EXP_ID, EXP_TS, 0);
    run_seq(1, 2, EXP_ID, EXP_TS, 1);
    run_seq(2, 255, EXP_ID, EXP_TS, 1);

    // asynchronous reset in the middle of a stalled ID read
    w_stall[0] = 255;
    w_stall[1] = 0;
    prev_read  = 1'b0;
    start      = 1'b1;
    slave_drive();
    @(posedge clock);
    #1;
    start = 1'b0;
    slave_drive();
    check_eq("pre_reset_in_rd_id", {62'd0, busy, avm_read}, 64'd3);
    #2;
    reset_n = 1'b0;
    #1;
    check_eq("midread_reset_ctrl",
             {57'd0, busy, done, avm_read, avm_address, id_ok, ts_ok, timeout_err}, 64'd0);
    check_eq("midread_reset_vals", {id_value, ts_value}, 64'd0);
    @(posedge clock);
    #1;
    check_eq("reset_held_no_done", {61'd0, busy, done, avm_read}, 64'd0);
    reset_n = 1'b1;
    slave_drive();
    @(posedge clock);
    #1;
    run_seq(0, 0, EXP_ID, EXP_TS, 0);

    for (int i = 0; i < 30; i++) begin
      int wi, wt;
      logic [31:0] di, dt;
      wi = $urandom_range(0, 6);
      wt = $urandom_range(0, 6);
      di = ($urandom_range(0, 1) == 1) ? EXP_ID : $urandom;
      dt = ($urandom_range(0, 1) == 1) ? EXP_TS : $urandom;
      run_seq(wi, wt, di, dt, 1'($urandom_range(0, 1)));
      idle_cycles($urandom_range(0, 2));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
